// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch next-PC generator.
// pc_width : PC/offset width in bits, derived from the instruction size in bytes.
// cnt_width: width of an occupancy counter that can hold 0..depth inclusive.
// Each fetch_pc_gen instance builds its queue-entry struct {pc, pred_next}
// (2*pc_width bits) locally, because the PC width is a per-instance parameter.
package fetch_pkg;

  function automatic int unsigned pc_width(input int unsigned instr_size_byte);
    return instr_size_byte * 8;
  endfunction

  function automatic int unsigned entry_width(input int unsigned instr_size_byte);
    return 2 * pc_width(instr_size_byte);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bundle between fetch_pc_gen and its environment.
// Carries the predictor fetch port (pc, nop, taken, offset), the stall input,
// the execute resolution inputs, the predictor update (exe) port, the flush
// pulse, the statistics counters and the underflow flag.
// master: the fetch_pc_gen side. slave: predictor/execute/environment side.
interface fetch_pc_gen_if #(
  parameter int unsigned W = 32
) ();
  logic         in_stall;
  logic [W-1:0] out_fetch_pc;
  logic         out_fetch_nop;
  logic         in_pred_taken;
  logic [W-1:0] in_pred_offset;
  logic         in_res_valid;
  logic         in_res_is_branch;
  logic         in_res_taken;
  logic [W-1:0] in_res_offset;
  logic [W-1:0] out_exe_pc;
  logic         out_exe_nop;
  logic         out_exe_branch_taken;
  logic [W-1:0] out_exe_branch_offset;
  logic         out_flush;
  logic [31:0]  out_branch_cnt;
  logic [31:0]  out_mispredict_cnt;
  logic         out_underflow_err;

  modport master (
    input  in_stall, in_pred_taken, in_pred_offset,
    input  in_res_valid, in_res_is_branch, in_res_taken, in_res_offset,
    output out_fetch_pc, out_fetch_nop,
    output out_exe_pc, out_exe_nop, out_exe_branch_taken, out_exe_branch_offset,
    output out_flush, out_branch_cnt, out_mispredict_cnt, out_underflow_err
  );

  modport slave (
    output in_stall, in_pred_taken, in_pred_offset,
    output in_res_valid, in_res_is_branch, in_res_taken, in_res_offset,
    input  out_fetch_pc, out_fetch_nop,
    input  out_exe_pc, out_exe_nop, out_exe_branch_taken, out_exe_branch_offset,
    input  out_flush, out_branch_cnt, out_mispredict_cnt, out_underflow_err
  );
endinterface

// File: rtl/pred_queue.sv
// In-order prediction queue: synchronous FIFO with clear.
// Ports: clk/rst_n (async active-low), clear_i (empties the queue, wins over
// push), push_i/wdata_i, pop_i, rdata_o (combinational head), count_o.
// Depth must be a power of 2 so the pointers wrap naturally.
module pred_queue import fetch_pkg::*; #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [Width-1:0]            wdata_i,
  output logic [Width-1:0]            rdata_o,
  output logic [cnt_width(Depth)-1:0] count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = cnt_width(Depth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    // A push into a full queue is only legal alongside a pop.
    do_push = push_i && !clear_i && ((count_q != DepthCnt) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries below count_q are ever consumed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator sitting in front of the pshare predictor.
// Ports: clk, rst_n (async active-low), bus (fetch_pc_gen_if.master):
//   fetch port  out_fetch_pc/out_fetch_nop, consumes in_pred_taken/in_pred_offset
//               in the same cycle; in_stall holds fetch.
//   resolution  in_res_* resolves the oldest in-flight instruction.
//   update port out_exe_* registered one cycle after a popped branch.
//   status      out_flush pulse, branch/mispredict counters, sticky underflow.
module fetch_pc_gen import fetch_pkg::*; #(
  parameter int unsigned                              INSTR_SIZE_BYTE = 4,
  parameter logic [pc_width(INSTR_SIZE_BYTE)-1:0]     RESET_PC        = '0,
  parameter int unsigned                              PQ_DEPTH        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_pc_gen_if.master bus
);
  localparam int unsigned W    = pc_width(INSTR_SIZE_BYTE);
  localparam int unsigned CntW = cnt_width(PQ_DEPTH);
  localparam logic [W-1:0]    Step     = W'(INSTR_SIZE_BYTE);
  localparam logic [CntW-1:0] DepthCnt = CntW'(PQ_DEPTH);

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] pred_next;
  } entry_t;

  entry_t          head, push_entry;
  logic [CntW-1:0] count;
  logic            pop, mis, fetch_en;
  logic [W-1:0]    actual_next, pred_next, pc_d;

  logic [W-1:0] pc_q;
  logic         flush_q;
  logic         exe_nop_q;
  logic [W-1:0] exe_pc_q;
  logic         exe_taken_q;
  logic [W-1:0] exe_offset_q;
  logic [31:0]  branch_cnt_q, mis_cnt_q;
  logic         underflow_q;

  always_comb begin
    pop         = bus.in_res_valid && (count != '0);
    actual_next = (bus.in_res_is_branch && bus.in_res_taken) ? head.pc + bus.in_res_offset
                                                             : head.pc + Step;
    mis         = pop && (actual_next != head.pred_next);
    // rst_n keeps out_fetch_nop high while reset is held.
    fetch_en    = rst_n && !bus.in_stall && !mis && ((count < DepthCnt) || pop);
    pred_next   = bus.in_pred_taken ? pc_q + bus.in_pred_offset : pc_q + Step;
    push_entry  = '{pc: pc_q, pred_next: pred_next};
    pc_d        = pc_q;
    if (mis)           pc_d = actual_next;
    else if (fetch_en) pc_d = pred_next;
  end

  pred_queue #(
    .Width (2 * W),
    .Depth (PQ_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (mis),
    .push_i  (fetch_en),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .count_o (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      flush_q      <= 1'b0;
      exe_nop_q    <= 1'b1;
      exe_pc_q     <= '0;
      exe_taken_q  <= 1'b0;
      exe_offset_q <= '0;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
      underflow_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      flush_q   <= mis;
      exe_nop_q <= !(pop && bus.in_res_is_branch);
      if (pop && bus.in_res_is_branch) begin
        exe_pc_q     <= head.pc;
        exe_taken_q  <= bus.in_res_taken;
        exe_offset_q <= bus.in_res_offset;
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mis) mis_cnt_q <= mis_cnt_q + 32'd1;
      if (bus.in_res_valid && (count == '0)) underflow_q <= 1'b1;
    end
  end

  assign bus.out_fetch_pc          = pc_q;
  assign bus.out_fetch_nop         = !fetch_en;
  assign bus.out_exe_pc            = exe_pc_q;
  assign bus.out_exe_nop           = exe_nop_q;
  assign bus.out_exe_branch_taken  = exe_taken_q;
  assign bus.out_exe_branch_offset = exe_offset_q;
  assign bus.out_flush             = flush_q;
  assign bus.out_branch_cnt        = branch_cnt_q;
  assign bus.out_mispredict_cnt    = mis_cnt_q;
  assign bus.out_underflow_err     = underflow_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the fetch/resolve rules.
module tb_fetch_pc_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_gen_if #(.W(32)) bus ();

  fetch_pc_gen #(
    .INSTR_SIZE_BYTE (4),
    .RESET_PC        (32'h0),
    .PQ_DEPTH        (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pn;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_exe_pc, m_exe_off, m_bcnt, m_mcnt;
  logic        m_flush, m_exe_nop, m_exe_taken, m_uf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_flush = 1'b0; m_exe_nop = 1'b1; m_exe_pc = '0;
    m_exe_taken = 1'b0; m_exe_off = '0; m_bcnt = '0; m_mcnt = '0; m_uf = 1'b0;
  endtask

  task automatic drive(input logic st, input logic pt, input logic [31:0] po, input logic rv,
                       input logic rb, input logic rt, input logic [31:0] ro);
    bus.in_stall = st; bus.in_pred_taken = pt; bus.in_pred_offset = po;
    bus.in_res_valid = rv; bus.in_res_is_branch = rb; bus.in_res_taken = rt;
    bus.in_res_offset = ro;
  endtask

  function automatic logic [31:0] dut_count();
    return 32'(u_dut.u_queue.count_o);
  endfunction

  // Release reset with fetch stalled so the first free-running fetch is at RESET_PC.
  task automatic release_reset();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    release_reset();
  endtask

  // Called at posedge+1: checks registered state, drives one cycle, advances the model.
  task automatic step(input logic st, input logic pt, input logic [31:0] po, input logic rv,
                      input logic rb, input logic rt, input logic [31:0] ro);
    logic        pop, mis, fe;
    logic [31:0] act, pn;
    ent_t        h;
    check("fetch_pc", bus.out_fetch_pc, m_pc);
    check("flush", 32'(bus.out_flush), 32'(m_flush));
    check("exe_nop", 32'(bus.out_exe_nop), 32'(m_exe_nop));
    check("exe_pc", bus.out_exe_pc, m_exe_pc);
    check("exe_taken", 32'(bus.out_exe_branch_taken), 32'(m_exe_taken));
    check("exe_offset", bus.out_exe_branch_offset, m_exe_off);
    check("branch_cnt", bus.out_branch_cnt, m_bcnt);
    check("mispredict_cnt", bus.out_mispredict_cnt, m_mcnt);
    check("underflow", 32'(bus.out_underflow_err), 32'(m_uf));
    check("pq_count", dut_count(), 32'(mq.size()));
    drive(st, pt, po, rv, rb, rt, ro);
    #1;
    pop = rv && (mq.size() > 0);
    mis = 1'b0;
    act = '0;
    h   = '{pc: '0, pn: '0};
    if (pop) begin
      h   = mq[0];
      act = (rb && rt) ? h.pc + ro : h.pc + 32'd4;
      mis = (act != h.pn);
    end
    fe = !st && !mis && ((mq.size() < 8) || pop);
    pn = pt ? m_pc + po : m_pc + 32'd4;
    check("fetch_nop", 32'(bus.out_fetch_nop), 32'(!fe));
    if (rv && (mq.size() == 0)) m_uf = 1'b1;
    m_exe_nop = 1'b1;
    if (pop) begin
      h = mq.pop_front();
      if (rb) begin
        m_bcnt++;
        m_exe_nop = 1'b0; m_exe_pc = h.pc; m_exe_taken = rt; m_exe_off = ro;
      end
    end
    m_flush = mis;
    if (mis) begin
      m_mcnt++;
      mq.delete();
      m_pc = act;
    end else if (fe) begin
      mq.push_back('{pc: m_pc, pn: pn});
      m_pc = pn;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        st, pt, rv, rb, rt;
    logic [31:0] po, ro;
    ent_t        h;

    // Reset state, with stall low to show nop is forced during reset.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    #12;
    check("rst_fetch_pc", bus.out_fetch_pc, 32'h0);
    check("rst_fetch_nop", 32'(bus.out_fetch_nop), 32'd1);
    check("rst_exe_nop", 32'(bus.out_exe_nop), 32'd1);
    check("rst_flush", 32'(bus.out_flush), 32'd0);
    check("rst_count", dut_count(), 32'd0);
    release_reset();

    // Sequential fetch 0,4,8,12.
    for (int i = 0; i < 4; i++) begin
      check("t1_seq_pc", bus.out_fetch_pc, 32'(i * 4));
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    end
    check("t1_count", dut_count(), 32'd4);

    // Correctly predicted taken branch at 0x10.
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, '0);
    check("t2_target", bus.out_fetch_pc, 32'h30);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h20);
    check("t2_flush", 32'(bus.out_flush), 32'd0);
    check("t2_branch_cnt", bus.out_branch_cnt, 32'd1);
    check("t2_mis_cnt", bus.out_mispredict_cnt, 32'd0);
    check("t2_exe_nop", 32'(bus.out_exe_nop), 32'd0);
    check("t2_exe_pc", bus.out_exe_pc, 32'h10);
    check("t2_exe_taken", 32'(bus.out_exe_branch_taken), 32'd1);
    check("t2_exe_offset", bus.out_exe_branch_offset, 32'h20);

    // Taken prediction resolved not-taken -> flush and redirect.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, '0);
    check("t3_target", bus.out_fetch_pc, 32'h18);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h8);
    check("t3_flush", 32'(bus.out_flush), 32'd1);
    check("t3_redirect", bus.out_fetch_pc, 32'h14);
    check("t3_count", dut_count(), 32'd0);
    check("t3_mis_cnt", bus.out_mispredict_cnt, 32'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("t3_flush_end", 32'(bus.out_flush), 32'd0);
    check("t3_resume", bus.out_fetch_pc, 32'h18);

    // Full queue holds fetch; a same-cycle correct resolution lets the push in.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("t4_full_count", dut_count(), 32'd8);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("t4_held_pc", bus.out_fetch_pc, 32'h20);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    check("t4_push_pc", bus.out_fetch_pc, 32'h24);
    check("t4_push_count", dut_count(), 32'd8);

    // Resolution on an empty queue.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h40);
    check("t5_underflow", 32'(bus.out_underflow_err), 32'd1);
    check("t5_branch_cnt", bus.out_branch_cnt, 32'd0);
    check("t5_mis_cnt", bus.out_mispredict_cnt, 32'd0);
    check("t5_exe_nop", 32'(bus.out_exe_nop), 32'd1);

    // Asynchronous reset mid-stream with 5 entries queued.
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("t6_pre_count", dut_count(), 32'd5);
    check("t6_pre_branch_cnt", bus.out_branch_cnt, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_count", dut_count(), 32'd0);
    check("t6_pc", bus.out_fetch_pc, 32'h0);
    check("t6_branch_cnt", bus.out_branch_cnt, 32'd0);
    check("t6_fetch_nop", 32'(bus.out_fetch_nop), 32'd1);
    release_reset();

    // PC wrap-around.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, '0);
    check("t7_top_pc", bus.out_fetch_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("t7_wrap_pc", bus.out_fetch_pc, 32'h0);

    // Randomized traffic; most resolutions agree with the queued prediction.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(3) == 0);
      pt = $urandom_range(1);
      po = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(63)) << 2;
      rv = $urandom_range(1);
      rb = $urandom_range(1);
      rt = $urandom_range(1);
      ro = 32'($urandom_range(63)) << 2;
      if (mq.size() > 0 && $urandom_range(3) != 0) begin
        h = mq[0];
        if (h.pn == h.pc + 32'd4) begin
          rt = 1'b0;
        end else begin
          rb = 1'b1;
          rt = 1'b1;
          ro = h.pn - h.pc;
        end
      end
      step(st, pt, po, rv, rb, rt, ro);
    end
    check("rand_final_pc", bus.out_fetch_pc, m_pc);
    check("rand_final_branch_cnt", bus.out_branch_cnt, m_bcnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-stage next-PC generator that sits directly upstream of the pshare predictor (ps_hp) and consumes its same-cycle prediction.
- Drives the predictor's fetch port and selects the next PC from the predicted taken/offset.
- Holds in-flight predictions in an in-order queue and checks them against execute resolutions.
- On a mismatch it redirects fetch and flushes. It also drives the predictor's registered update (exe) port.

Parameters:
- INSTR_SIZE_BYTE, 4, instruction size in bytes; PC and offset width is INSTR_SIZE_BYTE*8.
- RESET_PC, 0, PC value loaded on reset.
- PQ_DEPTH, 8, prediction-queue entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_stall  in  1  downstream stall; fetch holds while high.
- out_fetch_pc  out  W  PC presented to the predictor and the I-side.
- out_fetch_nop  out  1  1 = no fetch this cycle.
- in_pred_taken  in  1  predictor out_fetch_branch_taken, combinational in the same cycle.
- in_pred_offset  in  W  predictor out_pc_offset, as a byte offset.
- in_res_valid  in  1  execute resolves the oldest in-flight instruction.
- in_res_is_branch  in  1  the resolved instruction is a branch.
- in_res_taken  in  1  actual direction.
- in_res_offset  in  W  actual byte offset.
- out_exe_pc  out  W  predictor update PC.
- out_exe_nop  out  1  1 = no update this cycle.
- out_exe_branch_taken  out  1  update direction.
- out_exe_branch_offset  out  W  update offset.
- out_flush  out  1  one-cycle pulse: discard all younger work.
- out_branch_cnt  out  32  resolved branches.
- out_mispredict_cnt  out  32  mispredicted resolutions.
- out_underflow_err  out  1  sticky flag: a resolution arrived with the queue empty.

Behaviour:
- Reset state: pc_q=RESET_PC, queue empty, out_fetch_nop=1 during reset, all exe outputs 0 with out_exe_nop=1, out_flush=0, counters 0, out_underflow_err=0.
- Reset mid-operation: queue and counters are cleared immediately (asynchronous).
- Combinational outputs: out_fetch_pc=pc_q; out_fetch_nop = ~fetch_en.
- pop = in_res_valid and count>0.
- mis = pop and (actual_next != head.pred_next).
  - actual_next = (is_branch & taken) ? head.pc+in_res_offset : head.pc+INSTR_SIZE_BYTE.
  - Non-branch resolutions use taken=0.
- fetch_en = !in_stall and !mis and (count<PQ_DEPTH or pop).
- pred_next = in_pred_taken ? pc_q+in_pred_offset : pc_q+INSTR_SIZE_BYTE.
  - All adds are modulo 2^W; wrap-around is legal and silent.
- When fetch_en: push {pc_q, pred_next} into the queue; pc_q<=pred_next on the next edge.
- When mis: queue cleared (the head pop and every younger entry), the same-cycle push is suppressed, pc_q<=actual_next.
  - Next cycle: out_flush=1, and fetch resumes at actual_next unless in_stall is high.
- Simultaneous push and pop with no mis: count unchanged; allowed when the queue is full.
- in_stall: pc_q holds and no push. Resolutions are still accepted, and a mis still redirects pc_q.
- Resolution with the queue empty: ignored (no pop, no update, no count change); out_underflow_err<=1 until reset.
- Update port is registered, one cycle after the pop, only when head was popped and in_res_is_branch=1:
  - out_exe_nop=0, out_exe_pc=head.pc, out_exe_branch_taken=in_res_taken, out_exe_branch_offset=in_res_offset.
  - Otherwise out_exe_nop=1 and the data fields hold their last value.
- Counters:
  - out_branch_cnt increments on each popped branch.
  - out_mispredict_cnt increments on each mis, including a non-branch head whose pred_next was a taken target.
  - Both counters wrap at 2^32.
- Redirect latency: a resolution in cycle t produces a corrected out_fetch_pc in cycle t+1.

Decomposition:
- Shared package fetch_pkg: W derivation from INSTR_SIZE_BYTE, and a queue-entry struct {pc, pred_next} of width 2W.
- One natural sub-module: pred_queue, a synchronous FIFO with push, pop, clear and count.
  - Clear takes priority over push.
  - Read data is the head, combinational.
- Next-PC select, compare, counters and the update register stay in fetch_pc_gen.

Test Plan:
- Reset release, pred_taken=0, no stall: out_fetch_pc = 0,4,8,12 on consecutive cycles; out_fetch_nop=0; count=4.
- PC 0x10 with pred_taken=1, offset=0x20: next out_fetch_pc=0x30; resolve taken offset 0x20 -> no flush, branch_cnt=1, update port one cycle later: pc=0x10, taken=1, offset=0x20.
- Predict taken (pc 0x10, offset 8) -> next fetch at 0x18; resolve not-taken -> out_flush pulse, next out_fetch_pc=0x14, queue empty, mispredict_cnt=1.
- Fill the queue with 8 fetches and no resolutions -> 9th cycle out_fetch_nop=1, pc held; a same-cycle correct resolution lets the push proceed and count stays 8.
- Resolution with the queue empty -> out_underflow_err=1, counters unchanged, out_exe_nop stays 1.
- Assert rst_n low mid-stream with 5 entries queued -> immediately count=0, out_fetch_pc=RESET_PC, counters 0.
- PC 0xFFFFFFFC with pred_taken=0 -> next out_fetch_pc=0x00000000.
